// File: rtl/codificador_instruccion_if.sv
// Field-bundle input, memory write port and status of the RV32I instruction encoder.
// "slave" is the encoder's view; "master" is the loader/memory side.
interface codificador_instruccion_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_pulse;
  logic [1:0]        err_code;

  modport slave (
    input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err_pulse, err_code
  );

  modport master (
    output in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err_pulse, err_code
  );
endinterface

// File: rtl/codificador_instruccion.sv
// Packs decoded RV32I fields into R/I/S/B words, range-checks the immediate and
// streams the words into consecutive instruction-memory addresses.
module codificador_instruccion #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  codificador_instruccion_if.slave   bus
);

  localparam logic [2:0] T_R    = 3'd0;
  localparam logic [2:0] T_ILD  = 3'd1;
  localparam logic [2:0] T_IALU = 3'd2;
  localparam logic [2:0] T_S    = 3'd3;
  localparam logic [2:0] T_B    = 3'd4;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_BODD  = 2'b10;
  localparam logic [1:0] E_TYPE  = 2'b11;

  localparam logic [ADDR_W+1:0] CAP = {2'b01, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] word;
  } enc_t;

  logic              mem_we_q, mem_we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;

  enc_t              enc;
  logic signed [31:0] imm_s;
  logic              imm12_ok, imm13_ok;
  logic [ADDR_W+1:0] occupancy;
  logic              in_ready, accept, retire;

  // Range checks use the full 32-bit signed value so out-of-range values never alias.
  assign imm_s    = $signed(bus.in_imm);
  assign imm12_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign imm13_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);

  always_comb begin
    enc = '{err: E_NONE, word: 32'h0};
    unique case (bus.in_type)
      T_R:
        enc.word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
      T_ILD, T_IALU: begin
        enc.word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                    (bus.in_type == T_ILD) ? 7'b0000011 : 7'b0010011};
        if (!imm12_ok) enc.err = E_RANGE;
      end
      T_S: begin
        enc.word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:0], 7'b0100011};
        if (!imm12_ok) enc.err = E_RANGE;
      end
      T_B: begin
        enc.word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        if (bus.in_imm[0])  enc.err = E_BODD;
        else if (!imm13_ok) enc.err = E_RANGE;
      end
      default:
        enc.err = E_TYPE;
    endcase
  end

  // A pending word already claims the last slot, so stop accepting one bundle early.
  assign occupancy = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, mem_we_q};
  assign in_ready  = rst_n && !clear && (occupancy != CAP) && (!mem_we_q || bus.mem_ready);
  assign accept    = bus.in_valid && in_ready;
  assign retire    = mem_we_q && bus.mem_ready;

  always_comb begin
    mem_we_d    = mem_we_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    if (clear) begin
      mem_we_d   = 1'b0;
      count_d    = '0;
      err_code_d = E_NONE;
    end else begin
      if (retire) begin
        mem_we_d = 1'b0;
        count_d  = count_q + (ADDR_W+1)'(1);
      end
      if (accept) begin
        if (enc.err == E_NONE) begin
          mem_we_d = 1'b1;
          wdata_d  = enc.word;
        end else begin
          err_pulse_d = 1'b1;
          err_code_d  = enc.err;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      wdata_q     <= 32'h0;
      count_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= E_NONE;
    end else begin
      mem_we_q    <= mem_we_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_addr  = BASE_ADDR + 32'({count_q, 2'b00});
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CAP[ADDR_W:0]);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_codificador_instruccion.sv
// Randomized scoreboard bench for codificador_instruccion with a field-level reference model.
module tb_codificador_instruccion;
  localparam int          AW   = 2;
  localparam int          CAP  = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  codificador_instruccion_if #(.ADDR_W(AW)) bus ();

  codificador_instruccion #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc; logic [31:0] word; logic [2:0] ty; logic [31:0] imm;
    bit gv; logic [31:0] gold;
  } wexp_t;
  typedef struct { int unsigned cyc; logic [1:0] code; } eexp_t;
  typedef struct {
    bit v; logic [2:0] ty; logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7;
    logic [31:0] imm; bit mr; bit clr; bit rst; bit gv; logic [31:0] gold;
  } stim_t;

  wexp_t wq[$];
  eexp_t eq[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: rules taken straight from the field tables, as integer arithmetic.
  function automatic logic [1:0] classify(logic [2:0] ty, logic [31:0] imm);
    int v;
    v = $signed(imm);
    if (ty > 3'd4) return 2'b11;
    if (ty == 3'd4 && imm[0]) return 2'b10;
    if (ty >= 3'd1 && ty <= 3'd3 && (v < -2048 || v > 2047)) return 2'b01;
    if (ty == 3'd4 && (v < -4096 || v > 4094)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] encode(stim_t s);
    logic [31:0] r, op;
    case (s.ty)
      3'd0: op = 32'h33;
      3'd1: op = 32'h03;
      3'd2: op = 32'h13;
      3'd3: op = 32'h23;
      default: op = 32'h63;
    endcase
    r = op | (32'(s.f3) << 12) | (32'(s.rs1) << 15);
    case (s.ty)
      3'd0: r = r | (32'(s.rd) << 7) | (32'(s.rs2) << 20) | (32'(s.f7) << 25);
      3'd1, 3'd2: r = r | (32'(s.rd) << 7) | ((s.imm & 32'hFFF) << 20);
      3'd3: r = r | (32'(s.rs2) << 20) | ((s.imm & 32'h1F) << 7) | (((s.imm >> 5) & 32'h7F) << 25);
      default: r = r | (32'(s.rs2) << 20) | (((s.imm >> 1) & 32'hF) << 8) |
                   (((s.imm >> 11) & 32'h1) << 7) | (((s.imm >> 5) & 32'h3F) << 25) |
                   (((s.imm >> 12) & 32'h1) << 31);
    endcase
    return r;
  endfunction

  // The core's immediate decoder, used to round-trip every I/S/B word.
  function automatic int decode_imm(logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13: return int'($signed(w[31:20]));
      7'h23:        return int'($signed({w[31:25], w[11:7]}));
      7'h63:        return int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      default:      return 0;
    endcase
  endfunction

  function automatic stim_t mk(bit v, logic [2:0] ty, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic [2:0] f3, logic [31:0] imm, bit mr);
    stim_t s;
    s = '{v: v, ty: ty, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: 7'h20, imm: imm,
          mr: mr, clr: 1'b0, rst: 1'b0, gv: 1'b0, gold: 32'h0};
    return s;
  endfunction

  function automatic stim_t idle(bit mr);
    return mk(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, mr);
  endfunction

  // Driver-side model of occupancy, used to predict in_ready and which bundles are taken.
  int cnt = 0;
  bit pend = 1'b0;

  task automatic drive(stim_t s);
    bit exp_rdy, acc;
    logic [1:0] code;
    @(negedge clk); #1;
    rst_n = !s.rst;  clear = s.clr;
    bus.in_valid = s.v;  bus.in_type = s.ty;  bus.in_rd = s.rd;  bus.in_rs1 = s.rs1;
    bus.in_rs2 = s.rs2;  bus.in_funct3 = s.f3;  bus.in_funct7 = s.f7;  bus.in_imm = s.imm;
    bus.mem_ready = s.mr;
    #1;
    exp_rdy = !s.rst && !s.clr && (cnt + int'(pend) != CAP) && (!pend || s.mr);
    chk("in_ready", bus.in_ready, exp_rdy);
    acc = s.v && exp_rdy;
    if (s.rst || s.clr) begin
      cnt = 0; pend = 1'b0;
    end else begin
      if (pend && s.mr) begin cnt++; pend = 1'b0; end
      if (acc) begin
        code = classify(s.ty, s.imm);
        if (code == 2'b00) begin
          wq.push_back('{cyc: cyc, word: encode(s), ty: s.ty, imm: s.imm, gv: s.gv, gold: s.gold});
          pend = 1'b1;
        end else begin
          eq.push_back('{cyc: cyc, code: code});
        end
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  int  tally = 0;
  logic [1:0] mcode = 2'b00;
  initial begin
    bit exp_we, exp_p;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        wq.delete(); eq.delete(); tally = 0; mcode = 2'b00;
        continue;
      end
      exp_we = wq.size() > 0 && wq[0].cyc < cyc;
      chk("mem_we", bus.mem_we, exp_we);
      chk("count", bus.count, tally);
      chk("full", bus.full, tally == CAP);
      chk("mem_addr", bus.mem_addr, BASE + 32'(4 * tally));
      if (exp_we) begin
        chk("mem_wdata", bus.mem_wdata, wq[0].word);
        if (wq[0].gv) chk("golden_word", bus.mem_wdata, wq[0].gold);
        if (wq[0].ty != 3'd0) chk("imm_roundtrip", 32'(decode_imm(bus.mem_wdata)), wq[0].imm);
      end
      exp_p = eq.size() > 0 && eq[0].cyc == cyc - 1;
      chk("err_pulse", bus.err_pulse, exp_p);
      if (exp_p) begin
        mcode = eq[0].code;
        void'(eq.pop_front());
      end
      chk("err_code", bus.err_code, mcode);
      if (clear) begin
        wq.delete(); tally = 0; mcode = 2'b00;
      end else if (exp_we && bus.mem_ready) begin
        void'(wq.pop_front());
        tally++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    stim_t s;
    int bnd[10] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098, 4095, -1};
    bus.in_valid = 1'b0; bus.in_type = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0; bus.mem_ready = 1'b0;

    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, BASE);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_code", bus.err_code, 0);

    // addi x1, x0, -1, held once, then retired
    s = mk(1, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, -32'sd1, 0); s.gv = 1; s.gold = 32'hFFF00093; drive(s);
    drive(idle(0));
    drive(idle(1));
    drive(idle(1));
    s = idle(1); s.clr = 1; drive(s);

    // S then B back-to-back
    s = mk(1, 3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 1);      s.gv = 1; s.gold = 32'h0020A423; drive(s);
    s = mk(1, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 1);    s.gv = 1; s.gold = 32'hFE000EE3; drive(s);
    drive(idle(1)); drive(idle(1));

    // rejected bundles: odd B, I out of range, illegal type
    drive(mk(1, 3'd4, 5'd0, 5'd3, 5'd4, 3'd1, 32'd3, 1));
    drive(mk(1, 3'd1, 5'd5, 5'd6, 5'd0, 3'd2, 32'd2048, 1));
    drive(mk(1, 3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1));
    drive(idle(1)); drive(idle(1));

    // backpressure: three stalled cycles with a bundle waiting
    drive(mk(1, 3'd2, 5'd7, 5'd8, 5'd0, 3'd4, 32'd100, 0));
    for (int i = 0; i < 3; i++) drive(mk(1, 3'd3, 5'd0, 5'd9, 5'd10, 3'd2, -32'sd12, 0));
    drive(mk(1, 3'd3, 5'd0, 5'd9, 5'd10, 3'd2, -32'sd12, 1));
    drive(idle(1)); drive(idle(1));

    // fill to capacity, then clear restarts at BASE
    s = idle(1); s.clr = 1; drive(s);
    for (int i = 0; i < 7; i++) drive(mk(1, 3'd0, 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 32'h0, 1));
    s = idle(1); s.clr = 1; drive(s);
    drive(mk(1, 3'd2, 5'd3, 5'd4, 5'd0, 3'd0, 32'd5, 1));
    drive(idle(1));

    // reset while a word is stalled
    drive(mk(1, 3'd1, 5'd2, 5'd3, 5'd0, 3'd2, 32'd16, 0));
    drive(idle(0));
    s = idle(0); s.rst = 1; drive(s);
    @(posedge clk); #1;
    chk("mid_rst_mem_we", bus.mem_we, 0);
    chk("mid_rst_mem_addr", bus.mem_addr, BASE);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_full", bus.full, 0);
    chk("mid_rst_err_pulse", bus.err_pulse, 0);
    chk("mid_rst_err_code", bus.err_code, 0);

    for (int n = 0; n < 1500; n++) begin
      s = mk($urandom % 5 != 0, ($urandom % 8 == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5),
             5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 32'h0, $urandom % 4 != 0);
      s.f7 = 7'($urandom);
      case ($urandom % 4)
        0: s.imm = 32'($signed($urandom_range(0, 127)) - 64);
        1: s.imm = 32'(bnd[$urandom % 10]);
        2: s.imm = $urandom;
        default: s.imm = 32'($signed($urandom_range(0, 9000)) - 4500);
      endcase
      if (s.ty == 3'd4 && $urandom % 4 != 0) s.imm[0] = 1'b0;
      s.clr = ($urandom % 60 == 0);
      s.rst = ($urandom % 300 == 0);
      drive(s);
    end
    for (int i = 0; i < 4; i++) drive(idle(1));
    chk("drain_words", wq.size(), 0);
    chk("drain_errors", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/codificador_instruccion.md
# codificador_instruccion

Streaming RV32I instruction encoder: the write-side counterpart of the core's immediate/field decoder. It accepts decoded fields (type, registers, funct, signed immediate) over a valid/ready handshake, packs them into 32-bit R/I/S/B-type words, range-checks the immediate and writes the words sequentially into instruction memory. It sits between the test/boot loader and the instruction-memory write port, so instruction memory can be populated from field-level descriptions.

## Interface
Parameters:
- ADDR_W, 10, log2 of word capacity of the target memory region
- BASE_ADDR, 32'h0000_0000, byte address of first word written

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clear  in  1  synchronous restart: address/count/error reset, pending word dropped
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_type  in  3  0=R(0110011) 1=I-load(0000011) 2=I-alu(0010011) 3=S(0100011) 4=B(1100011), 5-7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_imm  in  32  signed immediate (byte offset for B)
- mem_we  out  1  write request / output valid
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  32  byte address of word
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  count == 2**ADDR_W
- err_pulse  out  1  one-cycle pulse on rejected bundle
- err_code  out  2  sticky last error: 00 none, 01 imm range, 10 B imm odd, 11 illegal type

## Operation
- Encoding: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}. R ignores in_imm; I/S/B ignore unused fields.
- Range: I/S require -2048 <= imm <= 2047; B requires -4096 <= imm <= 4094 and imm[0]=0. Compare full 32-bit signed value, not truncated bits.
- Error priority: illegal type (11) > odd B (10) > range (01).
- Accept = in_valid && in_ready at edge. Legal bundle: encoded word loaded into output register, mem_we=1. Rejected bundle: consumed, no write, err_pulse=1 next cycle, err_code updated, address/count unchanged.
- Output register holds word, address, mem_we until mem_we && mem_ready at an edge; then count +1, address +4.
- in_ready = rst_n && !clear && !full_pending && (!mem_we || mem_ready), where full_pending = (count + mem_we) == 2**ADDR_W.
- mem_addr = BASE_ADDR + 4*count.
- full: no further accepts; no wrap. Only clear or reset leaves full.
- clear: count=0, mem_we=0 (pending word discarded), err_code=00, err_pulse=0; no accept that cycle.

## Timing
- Reset values: in_ready=0 during reset, 1 after; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err_pulse=0, err_code=00.
- Latency: accept at edge N -> mem_we/mem_wdata valid after edge N (visible cycle N+1).
- Throughput: 1 word/cycle with mem_ready held high (accept and retire in same edge).
- mem_wdata/mem_addr stable while mem_we && !mem_ready.
- Reset mid-transfer: pending word dropped, no partial state retained.
- clear and accept same cycle: clear wins, bundle not accepted (in_ready already 0).
- Rejected bundle while output stalled: not accepted until output stall resolves (same in_ready rule).

## Test plan
- I-alu rd=1 rs1=0 f3=0 imm=-1 -> one cycle later mem_we=1, mem_wdata=0xFFF00093, mem_addr=BASE_ADDR; after retire count=1.
- S rs1=1 rs2=2 f3=2 imm=8, then B rs1=0 rs2=0 f3=0 imm=-4, mem_ready=1 -> 0x0020A423 at BASE, 0xFE000EE3 at BASE+4, back-to-back cycles.
- Errors: B imm=3 -> err_code=10; I imm=2048 -> 01; type=6 -> 11; each err_pulse one cycle, mem_we=0, count unchanged.
- Backpressure: mem_ready=0 for 3 cycles with pending word -> mem_wdata/mem_addr stable, in_ready=0; release -> retire, next accept same edge.
- ADDR_W=2: 4 legal writes -> count=4, full=1, in_ready=0 with in_valid=1; clear -> count=0, next word at BASE_ADDR.
- Reset asserted with mem_we=1, mem_ready=0 -> next cycle all outputs at reset values; round-trip every encoded I/S/B word through the core's immediate decoder and compare with in_imm.
